// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-request data-memory responder with programmable latency
// Word-organised array behind a load/store request port; flags range, alignment and conflict errors.
module dmem_responder #(
    parameter int                     ISA_WIDTH  = 32,
    parameter int                     DEPTH_LOG2 = 10,
    parameter logic [ISA_WIDTH-1:0]   BASE_ADDR  = 32'h8000_0000,
    parameter int                     LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ISA_WIDTH-1:0]  mem_addr,
    input  logic [ISA_WIDTH-1:0]  mem_w,
    input  logic [1:0]            mem_size,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    output logic                  req_ready,
    output logic [ISA_WIDTH-1:0]  mem_r,
    output logic                  mem_r_valid,
    output logic                  mem_w_done,
    output logic                  mem_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ISA_WIDTH-1:0]   r_addr;
    logic [ISA_WIDTH-1:0]   r_wdata;
    logic [1:0]             r_size;
    logic                   r_rd;
    logic                   r_wr;
    logic [3:0]             r_cnt;
    logic [ISA_WIDTH-1:0]   r_mem_r;
    logic [ISA_WIDTH-1:0]   r_mem [0:(1<<DEPTH_LOG2)-1];

    logic                   w_accept;
    logic [ISA_WIDTH-3:0]   w_woff;
    logic [DEPTH_LOG2-1:0]  w_index;
    logic [1:0]             w_lane;
    logic                   w_err;
    logic [ISA_WIDTH-1:0]   w_word;
    logic [ISA_WIDTH-1:0]   w_rdata;
    logic [3:0]             w_be;
    logic [ISA_WIDTH-1:0]   w_wdat;
    logic                   w_we;

    assign w_accept = (r_state == S_IDLE) && (mem_r_en || mem_w_en);

    // Word-granular offset: BASE_ADDR is word aligned, so the low two bits are the lane.
    assign w_woff  = r_addr[ISA_WIDTH-1:2] - BASE_ADDR[ISA_WIDTH-1:2];
    assign w_index = w_woff[DEPTH_LOG2-1:0];
    assign w_lane  = r_addr[1:0];
    assign w_word  = r_mem[w_index];

    always_comb begin
        w_err = 1'b0;
        if (r_rd && r_wr)
            w_err = 1'b1;
        if (r_size == 2'b11)
            w_err = 1'b1;
        if (|w_woff[ISA_WIDTH-3:DEPTH_LOG2])
            w_err = 1'b1;
        if ((r_size == 2'b01) && w_lane[0])
            w_err = 1'b1;
        if ((r_size == 2'b10) && (w_lane != 2'b00))
            w_err = 1'b1;
    end

    always_comb begin
        w_rdata = '0;
        case (r_size)
            2'b00:   w_rdata = ISA_WIDTH'(w_word[{w_lane, 3'b000} +: 8]);
            2'b01:   w_rdata = ISA_WIDTH'(w_word[{w_lane[1], 4'b0000} +: 16]);
            2'b10:   w_rdata = w_word;
            default: w_rdata = '0;
        endcase
        if (w_err)
            w_rdata = '0;
    end

    always_comb begin
        w_be   = 4'b0000;
        w_wdat = r_wdata;
        case (r_size)
            2'b00: begin
                w_be   = 4'b0001 << w_lane;
                w_wdat = {(ISA_WIDTH/8){r_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdat = {(ISA_WIDTH/16){r_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Commit at the edge closing RESP; a reset on that edge cancels the write.
    assign w_we = (r_state == S_RESP) && r_wr && !r_rd && !w_err && !rst;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b])
                    r_mem[w_index][8*b +: 8] <= w_wdat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_cnt   <= 4'd0;
            r_mem_r <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= mem_addr;
                r_wdata <= mem_w;
                r_size  <= mem_size;
                r_rd    <= mem_r_en;
                r_wr    <= mem_w_en;
                r_cnt   <= 4'(LATENCY);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if ((r_state == S_RESP) && r_rd)
                r_mem_r <= w_rdata;
        end
    end

    always_comb begin
        req_ready   = (r_state == S_IDLE);
        mem_r_valid = (r_state == S_RESP) && r_rd;
        mem_w_done  = (r_state == S_RESP) && r_wr && !r_rd;
        mem_err     = (r_state == S_RESP) && w_err;
        mem_r       = ((r_state == S_RESP) && r_rd) ? w_rdata : r_mem_r;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder
// Two instances share the request inputs: LATENCY=2 (main) and LATENCY=0 (fast).
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_w;
    logic [1:0]  mem_size;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        req_ready,  mem_r_valid,  mem_w_done,  mem_err;
    logic [31:0] mem_r;
    logic        req_ready0, mem_r_valid0, mem_w_done0, mem_err0;
    logic [31:0] mem_r0;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_responder #(.LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_w(mem_w), .mem_size(mem_size),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .req_ready(req_ready), .mem_r(mem_r),
        .mem_r_valid(mem_r_valid), .mem_w_done(mem_w_done), .mem_err(mem_err)
    );

    dmem_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_w(mem_w), .mem_size(mem_size),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .req_ready(req_ready0), .mem_r(mem_r0),
        .mem_r_valid(mem_r_valid0), .mem_w_done(mem_w_done0), .mem_err(mem_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        ren;
        logic        wen;
        logic        exp_rv;
        logic        exp_wd;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(input string nm, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic re, input logic we,
                       input logic rv, input logic wd, input logic er, input logic [31:0] rd);
        vec_t v;
        v.name = nm; v.addr = a; v.wdata = d; v.size = s; v.ren = re; v.wen = we;
        v.exp_rv = rv; v.exp_wd = wd; v.exp_err = er; v.exp_rd = rd;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge after the response pulse has ended.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          input logic re, input logic we, input string nm,
                          output int lat, output logic rv, output logic wd,
                          output logic er, output logic [31:0] rd);
        int g;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        mem_addr = a; mem_w = d; mem_size = s; mem_r_en = re; mem_w_en = we;
        @(negedge clk);
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        chk({nm, "_busy"}, {31'd0, req_ready}, 32'd0);
        lat = 1; rv = 1'b0; wd = 1'b0; er = 1'b0; rd = '0;
        while (lat <= 40) begin
            if (mem_r_valid || mem_w_done) begin
                rv = mem_r_valid; wd = mem_w_done; er = mem_err; rd = mem_r;
                break;
            end
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        chk({nm, "_pulse_end"}, {30'd0, mem_r_valid, mem_w_done}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic        rv, wd, er;
        logic [31:0] rd;

        add("w_word",      32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 0, 1, 0, 1, 0, 32'h0);
        add("r_word",      32'h8000_0010, 32'h0,         2'b10, 1, 0, 1, 0, 0, 32'hDEAD_BEEF);
        add("w_byte",      32'h8000_0013, 32'hFFFF_FFA5, 2'b00, 0, 1, 0, 1, 0, 32'h0);
        add("r_word2",     32'h8000_0010, 32'h0,         2'b10, 1, 0, 1, 0, 0, 32'hA5AD_BEEF);
        add("r_byte",      32'h8000_0013, 32'h0,         2'b00, 1, 0, 1, 0, 0, 32'h0000_00A5);
        add("r_half",      32'h8000_0012, 32'h0,         2'b01, 1, 0, 1, 0, 0, 32'h0000_A5AD);
        add("r_byte1",     32'h8000_0011, 32'h0,         2'b00, 1, 0, 1, 0, 0, 32'h0000_00BE);
        add("r_half0",     32'h8000_0010, 32'h0,         2'b01, 1, 0, 1, 0, 0, 32'h0000_BEEF);
        add("r_misalign",  32'h8000_0002, 32'h0,         2'b10, 1, 0, 1, 0, 1, 32'h0);
        add("w_half_mis",  32'h8000_0011, 32'h0000_FFFF, 2'b01, 0, 1, 0, 1, 1, 32'h0);
        add("r_after_mis", 32'h8000_0010, 32'h0,         2'b10, 1, 0, 1, 0, 0, 32'hA5AD_BEEF);
        add("r_size11",    32'h8000_0010, 32'h0,         2'b11, 1, 0, 1, 0, 1, 32'h0);
        add("r_past_end",  32'h8000_1000, 32'h0,         2'b10, 1, 0, 1, 0, 1, 32'h0);
        add("r_below",     32'h7FFF_FFFC, 32'h0,         2'b10, 1, 0, 1, 0, 1, 32'h0);
        add("both_en",     32'h8000_0010, 32'h0,         2'b10, 1, 1, 1, 0, 1, 32'h0);
        add("r_after_both",32'h8000_0010, 32'h0,         2'b10, 1, 0, 1, 0, 0, 32'hA5AD_BEEF);
        add("w_last",      32'h8000_0FFC, 32'h1122_3344, 2'b10, 0, 1, 0, 1, 0, 32'h0);
        add("r_last",      32'h8000_0FFC, 32'h0,         2'b10, 1, 0, 1, 0, 0, 32'h1122_3344);

        rst = 1'b1; mem_addr = '0; mem_w = '0; mem_size = 2'b00; mem_r_en = 1'b0; mem_w_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready},   32'd1);
        chk("rst_mem_r", mem_r,                32'd0);
        chk("rst_pulses", {29'd0, mem_r_valid, mem_w_done, mem_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_req(vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].ren, vecs[i].wen,
                   vecs[i].name, lat, rv, wd, er, rd);
            chk({vecs[i].name, "_lat"},   lat, 32'd3);
            chk({vecs[i].name, "_rv"},    {31'd0, rv}, {31'd0, vecs[i].exp_rv});
            chk({vecs[i].name, "_wd"},    {31'd0, wd}, {31'd0, vecs[i].exp_wd});
            chk({vecs[i].name, "_err"},   {31'd0, er}, {31'd0, vecs[i].exp_err});
            if (vecs[i].exp_rv)
                chk({vecs[i].name, "_data"}, rd, vecs[i].exp_rd);
        end

        // Continuous load requests: main accepts every 4 cycles, fast instance every 2.
        mem_addr = 32'h8000_0010; mem_size = 2'b10; mem_r_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("stream_ready_%0d", k),  {31'd0, req_ready},    {31'd0, (k % 4) == 0});
            chk($sformatf("stream_valid_%0d", k),  {31'd0, mem_r_valid},  {31'd0, (k % 4) == 3});
            chk($sformatf("stream0_ready_%0d", k), {31'd0, req_ready0},   {31'd0, (k % 2) == 0});
            chk($sformatf("stream0_valid_%0d", k), {31'd0, mem_r_valid0}, {31'd0, (k % 2) == 1});
            if ((k % 4) == 3)
                chk($sformatf("stream_data_%0d", k), mem_r, 32'hA5AD_BEEF);
            if ((k % 2) == 1)
                chk($sformatf("stream0_data_%0d", k), mem_r0, 32'hA5AD_BEEF);
            @(negedge clk);
        end
        mem_r_en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset while the store is waiting: nothing may be written or reported.
        mem_addr = 32'h8000_0010; mem_w = 32'h1234_5678; mem_size = 2'b10; mem_w_en = 1'b1;
        @(negedge clk);
        mem_w_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("midrst_nopulse_%0d", k), {30'd0, mem_r_valid, mem_w_done}, 32'd0);
            @(negedge clk);
        end
        do_req(32'h8000_0010, 32'h0, 2'b10, 1'b1, 1'b0, "midrst_read", lat, rv, wd, er, rd);
        chk("midrst_read_rv",   {31'd0, rv}, 32'd1);
        chk("midrst_read_data", rd,          32'hA5AD_BEEF);
        chk("midrst_read0_data", mem_r0,     32'hA5AD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
